// File: rtl/bitstream_arbiter.sv
// Round-robin front end that shares one serial "11" detector among N_REQ word sources.
// A granted word is shifted MSB-first through a saturating 2-bit Mealy detector,
// and the detection count is reported back with the requester index.
module bitstream_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     data,
  output logic [N_REQ-1:0]           grant,
  output logic                       busy,
  output logic                       x,
  output logic [1:0]                 sm_state,
  output logic                       done,
  output logic [$clog2(N_REQ)-1:0]   done_id,
  output logic [CW-1:0]              hit_count
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned XW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    cur;
  logic [WIDTH-1:0] word;
  logic [XW-1:0]    idx;
  logic [CW-1:0]    count;

  logic             any;
  logic [IW-1:0]    sel;
  logic [WIDTH-1:0] sel_word;
  logic             hit;
  logic [1:0]       sm_next;

  // Round-robin search starting at ptr; first requesting index wins.
  always_comb begin
    int unsigned j;
    logic [IW-1:0] cand;
    any      = 1'b0;
    sel      = '0;
    sel_word = '0;
    j        = 0;
    cand     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      cand = IW'(j);
      if (!any && req[cand]) begin
        any      = 1'b1;
        sel      = cand;
        sel_word = data[j*WIDTH +: WIDTH];
      end
    end
  end

  // Serial bit and detector next-state; x is forced low outside SHIFT.
  assign x = (state == SHIFT) ? word[idx] : 1'b0;

  // Saturating run counter of ones; a hit is a one following at least one one.
  always_comb begin
    hit     = x & (sm_state != 2'b00);
    sm_next = 2'b00;
    if (x) sm_next = (sm_state == 2'b11) ? 2'b11 : sm_state + 2'd1;
  end

  // Controller: arbitrate in IDLE, shift WIDTH bits, then report for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cur       <= '0;
      word      <= '0;
      idx       <= '0;
      count     <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      sm_state  <= 2'b00;
      done      <= 1'b0;
      done_id   <= '0;
      hit_count <= '0;
    end else begin
      grant <= '0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            word     <= sel_word;
            idx      <= XW'(WIDTH - 1);
            sm_state <= 2'b00;
            count    <= '0;
            grant    <= N_REQ'(1) << sel;
            cur      <= sel;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          count <= count + CW'(hit);
          idx   <= idx - XW'(1);
          if (idx == '0) begin
            // Detector returns to its rest state as the word leaves SHIFT.
            sm_state  <= 2'b00;
            done      <= 1'b1;
            done_id   <= cur;
            hit_count <= count + CW'(hit);
            state     <= REPORT;
          end else begin
            sm_state <= sm_next;
          end
        end
        REPORT: begin
          ptr   <= (cur == IW'(N_REQ - 1)) ? '0 : cur + IW'(1);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bitstream_arbiter.md
# bitstream_arbiter

Round-robin scheduler that shares one serial pattern-detector datapath among N requesters. Each requester presents a parallel word. The block grants one requester at a time, latches its word and shifts it MSB-first through an embedded 2-bit Mealy detector. It then reports the number of detections to the granted requester. It sits in front of the week-05 sequence-detector style datapath and sequences it, so multiple word sources can use a single detector.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, word length in bits (>=2)
- CW, $clog2(WIDTH), hit-count width (max count WIDTH-1)

- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- req  input  N_REQ  per-requester request level; held until granted
- data  input  N_REQ*WIDTH  requester i word at data[i*WIDTH +: WIDTH]
- grant  output  N_REQ  one-hot, 1-cycle pulse when a word is accepted
- busy  output  1  high from the grant cycle through the done cycle
- x  output  1  serial bit currently presented to the detector
- sm_state  output  2  detector state
- done  output  1  1-cycle pulse: result valid
- done_id  output  $clog2(N_REQ)  index of the requester that finished
- hit_count  output  CW  detections in the finished word

## Operation
- Controller FSM has three states: IDLE, SHIFT, REPORT.
- IDLE:
  - If any req bit is set, select the first set bit searching ptr, ptr+1, … mod N_REQ.
  - Latch its word; idx<=WIDTH-1; detector state<=2'b00; count<=0.
  - grant<=onehot(sel); cur<=sel; go to SHIFT.
  - If no req bit is set, remain in IDLE with all pulses low.
- SHIFT:
  - x = word[idx], combinational from registered values.
  - Every edge: update the detector; count += hit.
  - idx decrements each edge; the edge where idx==0 goes to REPORT.
- REPORT:
  - done=1, done_id=cur, hit_count=final count.
  - ptr<=(cur+1) mod N_REQ; next state IDLE.
- Detector, with s = sm_state:
  - x=0 → s<=00.
  - x=1 → s<=min(s+1, 3), saturating.
  - hit = x & (s!=00). This detects overlapping "11".
- Outside SHIFT: x=0 and sm_state holds 00.
- done_id and hit_count are registered. They hold their values until the next REPORT.
- req and data are sampled only in IDLE. Changes during SHIFT or REPORT are ignored. A req deasserted before grant is simply skipped.
- Reset, including mid-operation, forces the following values. No done pulse is produced for the aborted word.
  - State IDLE; ptr=0.
  - grant=0, busy=0, x=0, sm_state=00.
  - done=0, done_id=0, hit_count=0.

## Timing
- Cycle G is the cycle after the IDLE edge that accepts a request.
- In cycle G: grant pulse, busy=1, x=MSB.
- The WIDTH bits are presented in cycles G … G+WIDTH-1.
- In cycle G+WIDTH: done=1, busy=1.
- In cycle G+WIDTH+1: state is IDLE and arbitration occurs; the next grant is at G+WIDTH+2.
- With continuous requests, the grant-to-grant period is WIDTH+2 cycles.
- Count width: the count never overflows CW bits, since the maximum count is WIDTH-1.
- Any single-requester pattern, including a lone requester re-requesting, is served every WIDTH+2 cycles without starvation.

## Test plan
- Reset, then req=4'b0001 with word0=8'hFF → grant=0001 one cycle; done 8 cycles later with done_id=0, hit_count=7.
- Single-requester words 8'b11110000, 8'b10101010 and 8'b11011011 → hit_count 3, 0 and 3 respectively. Check sm_state per cycle for the first word: 01, 10, 11, 11, 00, 00, 00, 00 after each edge.
- req=4'b1111 held continuously from reset → grant order 0,1,2,3,0. Grants are spaced 10 cycles apart. Each done_id matches the preceding grant.
- req=4'b1010 with ptr=0 → grant 1 first, then 3, then 1. Drop req[3] before its turn → grant 1 repeats.
- Assert rst in cycle G+3 of a transfer → the next cycle has all outputs 0 and no done pulse. The subsequent req=4'b0100 is granted with ptr reset, so requester 2 is chosen by the search from 0.
- Change data for the granted requester during SHIFT → hit_count reflects the word latched at grant.
